bus_source_arbiter: RTL and testbench
=====================================

# bus_source_arbiter

Registered, parametrised bus-source select for the datapath's shared bus. It takes N_SRC per-source drive requests (R0out…R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Cout, … in index order) and produces a binary bus-mux select, a one-hot grant and a valid flag one cycle later. It supports fixed-priority or round-robin arbitration, grant hold for multi-cycle transfers, and conflict detection with a saturating counter. It sits between the control unit and the bus multiplexer.

## Interface
- N_SRC, 32, number of request sources; must be ≥ 2
- SEL_W, 5, select width; must be ≥ ceil(log2(N_SRC))
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- CNT_W, 8, conflict counter width
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- req  in  N_SRC  per-source drive request; bit i = source i
- hold  in  1  keep the current grant while its request stays asserted
- grant_sel  out  SEL_W  binary index of the granted source; drives the bus mux select
- grant_onehot  out  N_SRC  one-hot of the granted source; all zero when no grant
- grant_valid  out  1  a source is granted this cycle
- conflict  out  1  more than one req bit was set in the sampled cycle
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- All outputs are registered. req and hold are sampled at each rising clock edge.
- **Hold path:**
  - Condition: hold=1, grant_valid=1 and req[grant_sel]=1.
  - Result: grant_sel, grant_onehot and grant_valid are unchanged. The round-robin pointer is unchanged.
- **Hold release:**
  - Condition: hold=1 but req[grant_sel]=0.
  - Result: the grant is released and normal arbitration runs in the same cycle. Hold never blocks re-arbitration.
- **Arbitration** (hold path not taken, at least one req bit set):
  - MODE=0: grant the lowest set index.
  - MODE=1: search from ptr+1 upward and wrap from N_SRC-1 to 0. Grant the first set bit.
  - ptr is loaded with the granted index only when a grant is issued (new or re-issued).
  - Result: grant_valid=1, grant_sel=index, grant_onehot has only that bit set.
- **No request:** grant_valid=0 and grant_onehot=0. grant_sel keeps its previous value, so the mux select stays stable. ptr is unchanged.
- **Conflict detection:**
  - conflict is set to 1 when popcount(req) > 1 in the sampled cycle, otherwise 0. This is independent of hold and mode.
  - conflict_cnt increments by 1 on each such cycle and saturates at all-ones.
- **Index/width rules:**
  - grant_sel is zero-extended when SEL_W > ceil(log2(N_SRC)).
  - Indices ≥ N_SRC never occur.
- **Reset values:** grant_sel=0, grant_onehot=0, grant_valid=0, conflict=0, conflict_cnt=0, ptr=N_SRC-1. With ptr=N_SRC-1, the first round-robin search starts at index 0.
- **Reset mid-operation:** clear takes effect immediately, whatever the hold or grant state. The first edge after clear deasserts arbitrates from the reset state.

## Timing
- Latency is 1 cycle: req is sampled at edge k, and grant and conflict are valid after edge k.
- No combinational path from any input to any output.
- req may change every cycle. Each cycle's decision depends only on that edge's req and hold plus the registered state.
- grant_onehot and grant_sel always agree whenever grant_valid=1.
- A held grant persists for any number of cycles. It drops in the cycle after req[grant_sel] falls. If no other request is present, grant_valid=0 at that point.

## Test plan
- **Reset:** assert clear asynchronously mid-cycle with req=0x0000_0003 and hold=1 → all outputs 0 immediately. Release clear and hold req → grant_sel=0 and conflict=1 one edge later.
- **Fixed priority** (MODE=0): req=0x0010_8000 (PCout, R15out) → grant_sel=15, grant_onehot=0x0000_8000, conflict=1, conflict_cnt=1. Then req=0 → grant_valid=0, grant_sel stays 15.
- **Round-robin** (MODE=1): after reset, hold req=0x0000_0025 for 4 cycles → grant_sel sequence 0, 2, 5, 0. conflict_cnt=4.
- **Hold:** grant index 5, then hold=1 with req=0x0000_0021 for 3 cycles → grant_sel stays 5. Drop bit 5 with hold still 1 → the next edge grants 0 (MODE=0).
- **Saturation:** with CNT_W=2, hold req=0x3 for 6 cycles → conflict_cnt goes 1, 2, 3, 3, 3, 3.
- **Parameter sweep:** N_SRC=24, SEL_W=5, MODE=1, req=bit 23 only → grant_sel=23. Then req=bits 23 and 0 → grant_sel=0 (wrap).

Source files
------------

// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbiter port bundle: per-source requests in, bus-mux select and status out.
interface bus_source_arbiter_if #(
  parameter int unsigned N_SRC = 32,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned CNT_W = 8
);
  logic [N_SRC-1:0] req;
  logic             hold;
  logic [SEL_W-1:0] grant_sel;
  logic [N_SRC-1:0] grant_onehot;
  logic             grant_valid;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  // Control-unit side: drives requests, observes the grant.
  modport master (
    output req, hold,
    input  grant_sel, grant_onehot, grant_valid, conflict, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, hold,
    output grant_sel, grant_onehot, grant_valid, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// Registered bus-source select: fixed-priority or round-robin grant with hold,
// plus conflict detection and a saturating conflict counter. One cycle latency.
module bus_source_arbiter #(
  parameter int unsigned N_SRC = 32,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  bus_source_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N_SRC);

  logic [SEL_W-1:0] grant_sel_q,    grant_sel_nxt;
  logic [N_SRC-1:0] grant_onehot_q, grant_onehot_nxt;
  logic             grant_valid_q,  grant_valid_nxt;
  logic             conflict_q,     conflict_nxt;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_nxt;
  logic [SEL_W-1:0] ptr_q,          ptr_nxt;

  logic             hold_hit;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   cand_sum;

  // Winner search: lowest set index, or first set index after ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_sum  = '0;
    if (MODE == 0) begin
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
        if (bus.req[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Descending scan so the smallest offset from ptr ends up as the winner.
      for (int k = int'(N_SRC); k >= 1; k--) begin
        cand_sum = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(k);
        if (cand_sum >= (IDX_W+1)'(N_SRC)) begin
          cand_sum = cand_sum - (IDX_W+1)'(N_SRC);
        end
        cand = IDX_W'(cand_sum);
        if (bus.req[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Next-state: hold keeps the grant only while its own request stays up.
  always_comb begin
    grant_sel_nxt    = grant_sel_q;
    grant_onehot_nxt = grant_onehot_q;
    grant_valid_nxt  = grant_valid_q;
    ptr_nxt          = ptr_q;
    conflict_cnt_nxt = conflict_cnt_q;

    hold_hit = bus.hold && grant_valid_q && bus.req[IDX_W'(grant_sel_q)];

    if (!hold_hit) begin
      if (win_found) begin
        grant_sel_nxt    = SEL_W'(win_idx);
        grant_onehot_nxt = N_SRC'(1) << win_idx;
        grant_valid_nxt  = 1'b1;
        ptr_nxt          = SEL_W'(win_idx);
      end else begin
        // Select stays put so the bus mux does not toggle while idle.
        grant_onehot_nxt = '0;
        grant_valid_nxt  = 1'b0;
      end
    end

    conflict_nxt = ($countones(bus.req) > 1);
    if (conflict_nxt && (conflict_cnt_q != '1)) begin
      conflict_cnt_nxt = conflict_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers; ptr resets to the top index so RR starts at 0.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      grant_sel_q    <= '0;
      grant_onehot_q <= '0;
      grant_valid_q  <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
      ptr_q          <= SEL_W'(N_SRC - 1);
    end else begin
      grant_sel_q    <= grant_sel_nxt;
      grant_onehot_q <= grant_onehot_nxt;
      grant_valid_q  <= grant_valid_nxt;
      conflict_q     <= conflict_nxt;
      conflict_cnt_q <= conflict_cnt_nxt;
      ptr_q          <= ptr_nxt;
    end
  end

  assign bus.grant_sel    = grant_sel_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: four parameterisations share one stimulus
// stream; a behavioural model pushes expectations, compared after each edge.
module tb_bus_source_arbiter;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  // d0: fixed priority; d1: round-robin; d2: fixed, CNT_W=2; d3: N_SRC=24, RR.
  bus_source_arbiter_if #(.N_SRC(32), .SEL_W(5), .CNT_W(8)) if0 ();
  bus_source_arbiter_if #(.N_SRC(32), .SEL_W(5), .CNT_W(8)) if1 ();
  bus_source_arbiter_if #(.N_SRC(32), .SEL_W(5), .CNT_W(2)) if2 ();
  bus_source_arbiter_if #(.N_SRC(24), .SEL_W(5), .CNT_W(8)) if3 ();

  bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .MODE(0), .CNT_W(8)) u0 (.clock(clock), .clear(clear), .bus(if0.slave));
  bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .MODE(1), .CNT_W(8)) u1 (.clock(clock), .clear(clear), .bus(if1.slave));
  bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .MODE(0), .CNT_W(2)) u2 (.clock(clock), .clear(clear), .bus(if2.slave));
  bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .MODE(1), .CNT_W(8)) u3 (.clock(clock), .clear(clear), .bus(if3.slave));

  typedef struct {
    logic [31:0] sel;
    logic [31:0] oh;
    logic [31:0] valid;
    logic [31:0] conf;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int m_sel   [4];
  logic [31:0] m_oh [4];
  logic m_valid [4];
  logic m_conf  [4];
  int m_cnt   [4];
  int m_ptr   [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nsrc(input int d);
    return (d == 3) ? 24 : 32;
  endfunction

  function automatic int rr_mode(input int d);
    return (d == 1 || d == 3) ? 1 : 0;
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic exp_t dut_out(input int d);
    exp_t o;
    case (d)
      0: begin o.sel = 32'(if0.grant_sel); o.oh = 32'(if0.grant_onehot); o.valid = 32'(if0.grant_valid);
               o.conf = 32'(if0.conflict); o.cnt = 32'(if0.conflict_cnt); end
      1: begin o.sel = 32'(if1.grant_sel); o.oh = 32'(if1.grant_onehot); o.valid = 32'(if1.grant_valid);
               o.conf = 32'(if1.conflict); o.cnt = 32'(if1.conflict_cnt); end
      2: begin o.sel = 32'(if2.grant_sel); o.oh = 32'(if2.grant_onehot); o.valid = 32'(if2.grant_valid);
               o.conf = 32'(if2.conflict); o.cnt = 32'(if2.conflict_cnt); end
      default: begin o.sel = 32'(if3.grant_sel); o.oh = 32'(if3.grant_onehot); o.valid = 32'(if3.grant_valid);
               o.conf = 32'(if3.conflict); o.cnt = 32'(if3.conflict_cnt); end
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_sel[d] = 0; m_oh[d] = '0; m_valid[d] = 1'b0; m_conf[d] = 1'b0;
      m_cnt[d] = 0; m_ptr[d] = nsrc(d) - 1;
    end
  endtask

  task automatic model_step(input int d, input logic [31:0] r_in, input logic h);
    logic [31:0] r;
    int n;
    int idx;
    exp_t e;
    n   = nsrc(d);
    r   = (n == 32) ? r_in : (r_in & 32'h00FF_FFFF);
    idx = -1;
    if (!(h && m_valid[d] && r[m_sel[d]])) begin
      if (r != 0) begin
        if (rr_mode(d) == 0) begin
          for (int i = 0; i < n; i++) if (idx < 0 && r[i]) idx = i;
        end else begin
          for (int k = 1; k <= n; k++) if (idx < 0 && r[(m_ptr[d] + k) % n]) idx = (m_ptr[d] + k) % n;
        end
        m_sel[d] = idx; m_oh[d] = 32'h1 << idx; m_valid[d] = 1'b1; m_ptr[d] = idx;
      end else begin
        m_valid[d] = 1'b0; m_oh[d] = '0;
      end
    end
    m_conf[d] = ($countones(r) > 1);
    if (m_conf[d] && m_cnt[d] < cnt_max(d)) m_cnt[d]++;
    e.sel = 32'(m_sel[d]); e.oh = m_oh[d]; e.valid = 32'(m_valid[d]);
    e.conf = 32'(m_conf[d]); e.cnt = 32'(m_cnt[d]);
    sb.push_back(e);
  endtask

  // Called at a negedge: drive, predict, clock once, compare, return at next negedge.
  task automatic step(input logic [31:0] r, input logic h);
    exp_t e, o;
    if0.req = r; if1.req = r; if2.req = r; if3.req = r[23:0];
    if0.hold = h; if1.hold = h; if2.hold = h; if3.hold = h;
    for (int d = 0; d < 4; d++) model_step(d, r, h);
    @(posedge clock);
    #1;
    for (int d = 0; d < 4; d++) begin
      e = sb.pop_front();
      o = dut_out(d);
      check($sformatf("d%0d sel", d),   o.sel,   e.sel);
      check($sformatf("d%0d oh", d),    o.oh,    e.oh);
      check($sformatf("d%0d valid", d), o.valid, e.valid);
      check($sformatf("d%0d conf", d),  o.conf,  e.conf);
      check($sformatf("d%0d cnt", d),   o.cnt,   e.cnt);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    model_reset();
    @(negedge clock);
    clear = 1'b0;
  endtask

  logic [31:0] r;
  logic        h;
  int          sat_exp [6] = '{1, 2, 3, 3, 3, 3};
  int          rr_exp  [4] = '{0, 2, 5, 0};

  initial begin
    if0.req = '0; if1.req = '0; if2.req = '0; if3.req = '0;
    if0.hold = 1'b0; if1.hold = 1'b0; if2.hold = 1'b0; if3.hold = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("rst sel",   32'(if0.grant_sel), 32'd0);
    check("rst oh",    if0.grant_onehot, 32'd0);
    check("rst valid", 32'(if0.grant_valid), 32'd0);
    check("rst cnt",   32'(if1.conflict_cnt), 32'd0);
    clear = 1'b0;

    // Asynchronous clear mid-cycle while holding a grant.
    step(32'h0000_0003, 1'b1);
    step(32'h0000_0003, 1'b1);
    #2 clear = 1'b1;
    #1;
    model_reset();
    check("async sel",   32'(if0.grant_sel), 32'd0);
    check("async valid", 32'(if0.grant_valid), 32'd0);
    check("async oh",    if0.grant_onehot, 32'd0);
    check("async conf",  32'(if0.conflict), 32'd0);
    check("async cnt",   32'(if0.conflict_cnt), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    step(32'h0000_0003, 1'b1);
    check("post rst sel",  32'(if0.grant_sel), 32'd0);
    check("post rst conf", 32'(if0.conflict), 32'd1);

    // Fixed priority: PCout and R15out.
    do_reset();
    step(32'h0010_8000, 1'b0);
    check("fp sel",  32'(if0.grant_sel), 32'd15);
    check("fp oh",   if0.grant_onehot, 32'h0000_8000);
    check("fp conf", 32'(if0.conflict), 32'd1);
    check("fp cnt",  32'(if0.conflict_cnt), 32'd1);
    step(32'h0, 1'b0);
    check("fp idle valid", 32'(if0.grant_valid), 32'd0);
    check("fp idle sel",   32'(if0.grant_sel), 32'd15);

    // Round-robin rotation over sources 0, 2, 5.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(32'h0000_0025, 1'b0);
      check($sformatf("rr sel %0d", i), 32'(if1.grant_sel), 32'(rr_exp[i]));
    end
    check("rr cnt", 32'(if1.conflict_cnt), 32'd4);

    // Hold, then release when the held source drops.
    do_reset();
    step(32'h0000_0020, 1'b0);
    check("hold first", 32'(if0.grant_sel), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0021, 1'b1);
      check($sformatf("hold keep %0d", i), 32'(if0.grant_sel), 32'd5);
    end
    step(32'h0000_0001, 1'b1);
    check("hold release", 32'(if0.grant_sel), 32'd0);

    // Counter saturation with a 2-bit counter.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(32'h0000_0003, 1'b0);
      check($sformatf("sat cnt %0d", i), 32'(if2.conflict_cnt), 32'(sat_exp[i]));
    end

    // Non-power-of-two source count wraps from 23 to 0.
    do_reset();
    step(32'h0080_0000, 1'b0);
    check("n24 top", 32'(if3.grant_sel), 32'd23);
    step(32'h0080_0001, 1'b0);
    check("n24 wrap", 32'(if3.grant_sel), 32'd0);

    // Random traffic with sticky requests so hold paths get exercised.
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 32'h1 << $urandom_range(0, 31);
        2: r = $urandom & $urandom & $urandom;
        default: r = r ^ (32'h1 << $urandom_range(0, 31));
      endcase
      h = ($urandom_range(0, 2) != 0);
      step(r, h);
    end

    if (sb.size() != 0) check("sb drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
